uart_word_bridge: RTL and testbench

UART_WORD_BRIDGE -- requirements
Module: uart_word_bridge

---
 rtl/uart_word_bridge_pkg.sv | 28 ++
 rtl/uart_word_bridge.sv | 150 +++++++++++++++
 tb/tb_uart_word_bridge.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_word_bridge_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_word_bridge_pkg
//  Description : Shared defaults and transmit-FSM encodings for uart_word_bridge.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_word_bridge_pkg;

    localparam int c_DBIT_DEFAULT   = 8;
    localparam int c_NBYTES_DEFAULT = 4;

    localparam logic [1:0] c_TX_IDLE = 2'd0;
    localparam logic [1:0] c_TX_SEND = 2'd1;
    localparam logic [1:0] c_TX_WAIT = 2'd2;

    typedef enum logic [1:0] {
        TX_IDLE = c_TX_IDLE,
        TX_SEND = c_TX_SEND,
        TX_WAIT = c_TX_WAIT
    } tx_state_e;

    // Byte-counter width; a single-byte word still needs one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_word_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : uart_word_bridge
//  Description : Assembles UART receive bytes into words (LSB first) and
//                serialises words into bytes for the UART transmitter.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_word_bridge
    import uart_word_bridge_pkg::*;
#(
    parameter int DBIT   = c_DBIT_DEFAULT,
    parameter int NBYTES = c_NBYTES_DEFAULT
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     rx_empty,
    input  logic [DBIT-1:0]          r_data,
    output logic                     rd_uart,
    input  logic                     rx_clear,
    output logic [DBIT*NBYTES-1:0]   rx_word,
    output logic                     rx_valid,
    input  logic                     tx_start,
    input  logic [DBIT*NBYTES-1:0]   tx_in,
    output logic                     tx_ready,
    output logic                     tx_done,
    output logic                     wr_uart,
    output logic [DBIT-1:0]          w_data,
    input  logic                     tx_done_tick
);

    localparam int WORD_W  = DBIT * NBYTES;
    localparam int c_CNT_W = cnt_width(NBYTES);

    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(NBYTES - 1);
    localparam logic [c_CNT_W-1:0] c_ONE  = c_CNT_W'(1);

    // ------------------------------------------------------------------------
    // Receive assembler
    // ------------------------------------------------------------------------
    logic                 w_pop;
    logic [c_CNT_W-1:0]   r_rx_cnt_q,   w_rx_cnt_d;
    logic [WORD_W-1:0]    r_partial_q,  w_partial_d;
    logic [WORD_W-1:0]    r_rx_word_q,  w_rx_word_d;
    logic                 r_rx_valid_q, w_rx_valid_d;

    assign w_pop   = !rx_empty && !rx_clear && !reset;
    assign rd_uart = w_pop;

    always_comb begin
        w_rx_cnt_d   = r_rx_cnt_q;
        w_partial_d  = r_partial_q;
        w_rx_word_d  = r_rx_word_q;
        w_rx_valid_d = 1'b0;
        if (rx_clear) begin
            w_rx_cnt_d  = '0;
            w_partial_d = '0;
        end else if (w_pop) begin
            w_partial_d[int'(r_rx_cnt_q)*DBIT +: DBIT] = r_data;
            if (r_rx_cnt_q == c_LAST) begin
                w_rx_word_d  = w_partial_d;
                w_rx_valid_d = 1'b1;
                w_rx_cnt_d   = '0;
                w_partial_d  = '0;
            end else begin
                w_rx_cnt_d = r_rx_cnt_q + c_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_cnt_q   <= '0;
            r_partial_q  <= '0;
            r_rx_word_q  <= '0;
            r_rx_valid_q <= 1'b0;
        end else begin
            r_rx_cnt_q   <= w_rx_cnt_d;
            r_partial_q  <= w_partial_d;
            r_rx_word_q  <= w_rx_word_d;
            r_rx_valid_q <= w_rx_valid_d;
        end
    end

    // ------------------------------------------------------------------------
    // Transmit serializer
    // ------------------------------------------------------------------------
    tx_state_e            r_tx_state_q, w_tx_state_d;
    logic [WORD_W-1:0]    r_shift_q,    w_shift_d;
    logic [c_CNT_W-1:0]   r_tx_idx_q,   w_tx_idx_d;
    logic                 r_tx_done_q,  w_tx_done_d;

    always_comb begin
        w_tx_state_d = r_tx_state_q;
        w_shift_d    = r_shift_q;
        w_tx_idx_d   = r_tx_idx_q;
        w_tx_done_d  = 1'b0;
        case (r_tx_state_q)
            TX_IDLE: begin
                if (tx_start) begin
                    w_shift_d    = tx_in;
                    w_tx_idx_d   = '0;
                    w_tx_state_d = TX_SEND;
                end
            end
            TX_SEND: begin
                w_tx_state_d = TX_WAIT;
            end
            TX_WAIT: begin
                if (tx_done_tick) begin
                    if (r_tx_idx_q == c_LAST) begin
                        w_tx_state_d = TX_IDLE;
                        w_tx_done_d  = 1'b1;
                    end else begin
                        w_shift_d    = r_shift_q >> DBIT;
                        w_tx_idx_d   = r_tx_idx_q + c_ONE;
                        w_tx_state_d = TX_SEND;
                    end
                end
            end
            default: begin
                w_tx_state_d = TX_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tx_state_q <= TX_IDLE;
            r_shift_q    <= '0;
            r_tx_idx_q   <= '0;
            r_tx_done_q  <= 1'b0;
        end else begin
            r_tx_state_q <= w_tx_state_d;
            r_shift_q    <= w_shift_d;
            r_tx_idx_q   <= w_tx_idx_d;
            r_tx_done_q  <= w_tx_done_d;
        end
    end

    // Outputs are forced to their reset values for the whole reset period,
    // including the first cycle before the registers have been cleared.
    assign rx_word  = reset ? '0 : r_rx_word_q;
    assign rx_valid = r_rx_valid_q && !reset;
    assign tx_done  = r_tx_done_q && !reset;
    assign wr_uart  = (r_tx_state_q == TX_SEND) && !reset;
    assign tx_ready = (r_tx_state_q == TX_IDLE) || reset;
    assign w_data   = reset ? '0 : r_shift_q[DBIT-1:0];

endmodule
`default_nettype wire

// File: tb/tb_uart_word_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_word_bridge
//  Description : Self-checking bench for uart_word_bridge with FIFO/UART models.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_word_bridge;

    localparam int DBIT   = 8;
    localparam int NBYTES = 4;
    localparam int WORD_W = DBIT * NBYTES;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              rx_empty = 1'b1;
    logic [DBIT-1:0]   r_data = '0;
    logic              rx_clear = 1'b0;
    logic              tx_start = 1'b0;
    logic [WORD_W-1:0] tx_in = '0;
    logic              tx_done_tick = 1'b0;
    logic              rd_uart, rx_valid, tx_ready, tx_done, wr_uart;
    logic [WORD_W-1:0] rx_word;
    logic [DBIT-1:0]   w_data;

    uart_word_bridge #(.DBIT(DBIT), .NBYTES(NBYTES)) dut (
        .clk(clk), .reset(reset), .rx_empty(rx_empty), .r_data(r_data),
        .rd_uart(rd_uart), .rx_clear(rx_clear), .rx_word(rx_word),
        .rx_valid(rx_valid), .tx_start(tx_start), .tx_in(tx_in),
        .tx_ready(tx_ready), .tx_done(tx_done), .wr_uart(wr_uart),
        .w_data(w_data), .tx_done_tick(tx_done_tick)
    );

    always #10 clk = ~clk;

    // Environment model state
    logic [7:0]  fifo[$];
    logic [7:0]  wr_log[$];
    int          wr_cyc[$];
    logic [31:0] rxw_log[$];
    int cyc = 0, pops = 0, first_pop_cyc = -1, last_pop_cyc = -1, rxv_cyc = -1;
    int done_cnt = 0, done_cyc = -1, tick_cnt = 0, tick_dly = 20, last_tick_cyc = -1;
    int n_tests = 0, n_fail = 0;

    typedef struct {
        logic rst, empty, clr;
        logic exp_rd, exp_ready;
    } vec_t;
    vec_t tbl[8];

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endfunction

    task automatic refresh();
        rx_empty = (fifo.size() == 0);
        r_data   = rx_empty ? 8'h00 : fifo[0];
        #1;
    endtask

    // One clock: FIFO pops, UART transmitter reply and output logging.
    task automatic tick();
        logic pop;
        pop = rd_uart;
        @(posedge clk);
        #1;
        cyc++;
        tx_done_tick = 1'b0;
        if (pop) begin
            if (fifo.size() > 0) void'(fifo.pop_front());
            pops++;
            if (first_pop_cyc < 0) first_pop_cyc = cyc;
            last_pop_cyc = cyc;
        end
        if (tick_cnt > 0) begin
            tick_cnt--;
            if (tick_cnt == 0) begin
                tx_done_tick  = 1'b1;
                last_tick_cyc = cyc;
            end
        end
        if (wr_uart) begin
            wr_log.push_back(w_data);
            wr_cyc.push_back(cyc);
            tick_cnt = tick_dly;
        end
        if (rx_valid) begin
            rxw_log.push_back(rx_word);
            rxv_cyc = cyc;
        end
        if (tx_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        refresh();
    endtask

    task automatic clear_logs();
        wr_log.delete();
        wr_cyc.delete();
        rxw_log.delete();
        pops = 0; first_pop_cyc = -1; last_pop_cyc = -1; rxv_cyc = -1;
        done_cnt = 0; done_cyc = -1;
    endtask

    task automatic push_bytes(input logic [31:0] w);
        for (int b = 0; b < NBYTES; b++) fifo.push_back(8'(w >> (8 * b)));
        refresh();
    endtask

    initial begin
        #(20 * 60000);
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        logic dropped;
        logic [63:0] exp_words[$];

        tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

        // Reset state
        reset = 1'b1;
        refresh();
        for (int i = 0; i < 3; i++) tick();
        check("reset rx_word",  64'(rx_word), 64'h0);
        check("reset rx_valid", 64'(rx_valid), 64'h0);
        check("reset tx_done",  64'(tx_done), 64'h0);
        check("reset wr_uart",  64'(wr_uart), 64'h0);
        check("reset w_data",   64'(w_data), 64'h0);
        check("reset rd_uart",  64'(rd_uart), 64'h0);
        check("reset tx_ready", 64'(tx_ready), 64'h1);

        // Pop-strobe truth table, applied between clock edges so no pop is taken
        for (int i = 0; i < 8; i++) begin
            reset    = tbl[i].rst;
            rx_empty = tbl[i].empty;
            rx_clear = tbl[i].clr;
            r_data   = 8'hA5;
            #1;
            check($sformatf("table[%0d] rd_uart", i), 64'(rd_uart), 64'(tbl[i].exp_rd));
            check($sformatf("table[%0d] tx_ready", i), 64'(tx_ready), 64'(tbl[i].exp_ready));
        end
        reset = 1'b1; rx_clear = 1'b0;
        refresh();
        tick();
        reset = 1'b0;
        tick();

        // Back-to-back receive of one word
        clear_logs();
        push_bytes(32'h44332211);
        for (int i = 0; i < 8; i++) tick();
        check("rx b2b pops", 64'(pops), 64'd4);
        check("rx b2b consecutive", 64'(last_pop_cyc - first_pop_cyc), 64'd3);
        check("rx b2b valid count", 64'(rxw_log.size()), 64'd1);
        if (rxw_log.size() > 0) check("rx b2b word", 64'(rxw_log[0]), 64'h44332211);
        check("rx b2b valid latency", 64'(rxv_cyc), 64'(last_pop_cyc));
        check("rx_word holds", 64'(rx_word), 64'h44332211);

        // Partial word discarded by rx_clear
        clear_logs();
        fifo.push_back(8'hAA); fifo.push_back(8'hBB);
        refresh();
        for (int i = 0; i < 4; i++) tick();
        rx_clear = 1'b1;
        tick();
        rx_clear = 1'b0;
        push_bytes(32'h04030201);
        for (int i = 0; i < 8; i++) tick();
        check("rx clear valid count", 64'(rxw_log.size()), 64'd1);
        if (rxw_log.size() > 0) check("rx clear word", 64'(rxw_log[0]), 64'h04030201);

        // Transmit 0xDEADBEEF with a 20-cycle UART
        clear_logs();
        tick_dly = 20;
        tx_in = 32'hDEADBEEF; tx_start = 1'b1;
        s = cyc;
        tick();
        tx_start = 1'b0;
        check("tx busy ready", 64'(tx_ready), 64'h0);
        for (int k = 0; k < 300 && done_cnt == 0; k++) tick();
        check("tx1 done seen", 64'(done_cnt), 64'd1);
        check("tx1 wr count", 64'(wr_log.size()), 64'd4);
        if (wr_log.size() == 4) begin
            check("tx1 byte0", 64'(wr_log[0]), 64'hEF);
            check("tx1 byte1", 64'(wr_log[1]), 64'hBE);
            check("tx1 byte2", 64'(wr_log[2]), 64'hAD);
            check("tx1 byte3", 64'(wr_log[3]), 64'hDE);
            check("tx1 start latency", 64'(wr_cyc[0]), 64'(s + 1));
        end
        check("tx1 done latency", 64'(done_cyc), 64'(last_tick_cyc + 1));
        check("tx1 ready after", 64'(tx_ready), 64'h1);
        tick();
        check("tx1 done pulse width", 64'(tx_done), 64'h0);

        // tx_start held through a transmission is ignored until idle
        clear_logs();
        tick_dly = 3;
        tx_in = 32'hA1B2C3D4; tx_start = 1'b1;
        tick();
        tx_in = 32'h12345678;
        dropped = 1'b0;
        for (int k = 0; k < 300 && done_cnt < 2; k++) begin
            tick();
            if (done_cnt == 1 && !tx_ready && !dropped) begin
                tx_start = 1'b0;
                dropped  = 1'b1;
            end
        end
        tx_start = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check("hold done count", 64'(done_cnt), 64'd2);
        check("hold wr count", 64'(wr_log.size()), 64'd8);
        exp_words = '{64'hD4, 64'hC3, 64'hB2, 64'hA1, 64'h78, 64'h56, 64'h34, 64'h12};
        if (wr_log.size() == 8)
            for (int b = 0; b < 8; b++)
                check($sformatf("hold byte%0d", b), 64'(wr_log[b]), exp_words[b]);

        // Reset in the middle of a transmission and a partial receive
        clear_logs();
        tick_dly = 20;
        fifo.push_back(8'h55); fifo.push_back(8'h66);
        refresh();
        tx_in = 32'hCAFEBABE; tx_start = 1'b1;
        tick();
        tx_start = 1'b0;
        for (int k = 0; k < 200 && wr_log.size() < 2; k++) tick();
        check("rst-mid wr reached 2", 64'(wr_log.size()), 64'd2);
        reset = 1'b1;
        tick();
        check("rst-mid tx_ready", 64'(tx_ready), 64'h1);
        check("rst-mid wr_uart", 64'(wr_uart), 64'h0);
        reset = 1'b0;
        for (int i = 0; i < 60; i++) tick();
        check("rst-mid no tx_done", 64'(done_cnt), 64'd0);
        check("rst-mid no more wr", 64'(wr_log.size()), 64'd2);
        push_bytes(32'hF0DEBC9A);
        for (int i = 0; i < 8; i++) tick();
        check("rst-mid rx count", 64'(rxw_log.size()), 64'd1);
        if (rxw_log.size() > 0) check("rst-mid rx word", 64'(rxw_log[0]), 64'hF0DEBC9A);

        // Stray tx_done_tick while idle
        clear_logs();
        tx_done_tick = 1'b1;
        #1;
        tick();
        check("stray ready", 64'(tx_ready), 64'h1);
        check("stray wr_uart", 64'(wr_uart), 64'h0);
        tick();
        check("stray tx_done", 64'(done_cnt), 64'd0);

        // Randomised concurrent receive and transmit against a word-level model
        for (int it = 0; it < 25; it++) begin
            logic [31:0] w;
            logic [31:0] exp_rx;
            logic [7:0]  rb[4];
            int          d;
            int          bi;
            w = $urandom;
            d = $urandom_range(1, 6);
            exp_rx = '0;
            for (int b = 0; b < 4; b++) begin
                rb[b]  = 8'($urandom_range(0, 255));
                exp_rx = exp_rx + (32'(rb[b]) << (8 * b));
            end
            clear_logs();
            tick_dly = d;
            bi = 0;
            tx_in = w; tx_start = 1'b1;
            s = cyc;
            tick();
            tx_start = 1'b0;
            for (int k = 0; k < 600 && (rxw_log.size() == 0 || done_cnt == 0); k++) begin
                if (bi < 4 && $urandom_range(0, 2) != 0) begin
                    fifo.push_back(rb[bi]);
                    bi++;
                    refresh();
                end
                tick();
            end
            check($sformatf("rand%0d rx count", it), 64'(rxw_log.size()), 64'd1);
            if (rxw_log.size() > 0) check($sformatf("rand%0d rx word", it), 64'(rxw_log[0]), 64'(exp_rx));
            check($sformatf("rand%0d done", it), 64'(done_cnt), 64'd1);
            check($sformatf("rand%0d wr count", it), 64'(wr_log.size()), 64'd4);
            if (wr_log.size() == 4) begin
                check($sformatf("rand%0d first wr", it), 64'(wr_cyc[0]), 64'(s + 1));
                for (int b = 0; b < 4; b++)
                    check($sformatf("rand%0d tx byte%0d", it, b), 64'(wr_log[b]), 64'(8'(w >> (8 * b))));
                for (int b = 0; b < 3; b++)
                    check($sformatf("rand%0d wr gap%0d", it, b), 64'(wr_cyc[b + 1] - wr_cyc[b]), 64'(d + 1));
                check($sformatf("rand%0d done latency", it), 64'(done_cyc), 64'(wr_cyc[3] + d + 1));
            end
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
